conv_mac_stage: RTL and testbench
=================================

// Module: conv_mac_stage
// PURPOSE
//  Downstream consumer of the convolution-engine line FIFO. Pops KernelSize
//  pixels per window and multiplies each by a stored signed weight. Accumulates
//  the products and presents one signed result per window on a valid/ready
//  output. Weights are loaded through a simple write port while the stage is idle.
// PARAMETERS
//  DataWidth   32  width of FIFO data word (signed pixel)
//  WeightWidth 8   width of one signed weight
//  KernelSize  9   taps per window (weight RAM depth), >=2
//  TapWidth    4   counter/address width, 2**TapWidth >= KernelSize
//  AccWidth    44  accumulator/result width, >= DataWidth+WeightWidth+TapWidth
// PORTS
//  clk         in   1            rising-edge clock
//  aclr        in   1            asynchronous reset, active-high
//  Enable      in   1            level: 1 = run windows, 0 = go idle at window boundary
//  FifoReady   in   1            FIFO holds >=1 readable word
//  FifoData    in   DataWidth    FIFO read data, valid cycle after Pop
//  Pop         out  1            FIFO read strobe
//  W_Load      in   1            weight write strobe
//  W_Addr      in   TapWidth     weight index 0..KernelSize-1
//  W_Data      in   WeightWidth  signed weight
//  Result      out  AccWidth     signed window sum
//  ResultValid out  1            Result holds a completed window
//  ResultReady in   1            downstream accepts Result
//  Busy        out  1            state != IDLE
//  Test_Tap    out  TapWidth     accumulate counter, for bench visibility
// BEHAVIOUR
//  - Reset (aclr=1, any time): state=IDLE, Pop=0, Result=0, ResultValid=0,
//    counters=0, accumulator=0, in-flight flag=0; weights reset to 0.
//  - States: IDLE, RUN, OUT.
//    IDLE->RUN when Enable=1. RUN->OUT on the final accumulate. OUT->RUN on
//    ResultValid&ResultReady with Enable=1. OUT->IDLE on that handshake with Enable=0.
//  - Pop = (state==RUN) & FifoReady & (pop_cnt<KernelSize); combinational.
//    pop_cnt increments per Pop. Pop is never asserted in IDLE or OUT.
//  - Read latency 1: pop_d <= Pop. When pop_d=1, the stage adds
//    sext(FifoData)*sext(weight[acc_cnt]) to the accumulator and increments acc_cnt.
//  - When pop_d=1 and acc_cnt==KernelSize-1: Result <= acc+product, ResultValid<=1,
//    acc<=0, acc_cnt<=0, pop_cnt<=0, state<=OUT.
//  - In OUT: Result/ResultValid held stable until ResultReady; ResultValid drops
//    the cycle after handshake; no Pop during OUT or in handshake cycle.
//  - Enable=0 mid-window is ignored until window completes (no partial results).
//  - W_Load honoured only in IDLE; ignored otherwise and for W_Addr>=KernelSize.
//  - Signed arithmetic throughout; product DataWidth+WeightWidth bits, sign-
//    extended to AccWidth; no saturation, wraps modulo 2**AccWidth.
//  - FifoReady low mid-window: Pop stalls, accumulator holds; resumes seamlessly.
//  - Busy = (state!=IDLE). Test_Tap = acc_cnt.
// CONFIGURATION
//  CONV_MAC_RELU_EN defined: value registered into Result is max(sum,0); a
//    negative window produces Result=0 with ResultValid=1 as normal.
//  Not defined: Result is the raw signed sum; no other difference, same latency.
// TESTING
//  1 aclr pulse mid-window (acc_cnt=4) -> all outputs 0, state IDLE next cycle.
//  2 weights all 1, FIFO words 1..9 continuous, Enable=1 -> 9 Pops in 9
//    cycles, Result=45, ResultValid 1 cycle after 9th Pop's data edge.
//  3 weights 0..8, data all -2, ResultReady=0 for 5 cycles -> Result=-72 held,
//    Pop=0 throughout; one cycle after handshake Pop resumes.
//  4 FifoReady toggling 1,0,1,0 with weights 1, data 3 -> Result=27 unchanged.
//  5 W_Load while RUN -> weight unchanged; Enable=0 mid-window -> window completes,
//    then IDLE after handshake.
//  6 CONV_MAC_RELU_EN on, data -1 weights 1 -> Result=0; off -> Result=-9.

Source files
------------

// File: rtl/conv_mac_stage_if.sv
// ---------------------------------------------------------------------------
// conv_mac_stage_if
//   Groups the FIFO read side, weight write port, result handshake and status
//   signals of conv_mac_stage into one bundle.
//
//   slave  modport : the MAC stage itself
//   master modport : whatever drives it (FIFO + control + result consumer)
//
//   Enable       control level, 1 = run windows
//   FifoReady    FIFO holds at least one readable word
//   FifoData     FIFO read data, valid the cycle after Pop
//   Pop          FIFO read strobe
//   W_Load       weight write strobe
//   W_Addr       weight index
//   W_Data       signed weight value
//   Result       signed window sum
//   ResultValid  Result holds a completed window
//   ResultReady  downstream accepts Result
//   Busy         stage is not idle
//   Test_Tap     accumulate counter, for observation
// ---------------------------------------------------------------------------
interface conv_mac_stage_if #(
  parameter int DataWidth   = 32,
  parameter int WeightWidth = 8,
  parameter int TapWidth    = 4,
  parameter int AccWidth    = 44
);
  logic                   Enable;
  logic                   FifoReady;
  logic [DataWidth-1:0]   FifoData;
  logic                   Pop;
  logic                   W_Load;
  logic [TapWidth-1:0]    W_Addr;
  logic [WeightWidth-1:0] W_Data;
  logic [AccWidth-1:0]    Result;
  logic                   ResultValid;
  logic                   ResultReady;
  logic                   Busy;
  logic [TapWidth-1:0]    Test_Tap;

  modport slave (
    input  Enable, FifoReady, FifoData, W_Load, W_Addr, W_Data, ResultReady,
    output Pop, Result, ResultValid, Busy, Test_Tap
  );

  modport master (
    output Enable, FifoReady, FifoData, W_Load, W_Addr, W_Data, ResultReady,
    input  Pop, Result, ResultValid, Busy, Test_Tap
  );
endinterface

// File: rtl/conv_mac_stage.sv
// ---------------------------------------------------------------------------
// conv_mac_stage
//   Consumer of the convolution line FIFO. Each window pops KernelSize pixels,
//   multiplies each by its stored signed weight, accumulates, and presents the
//   signed window sum on a valid/ready output. Weights are written only while
//   the stage is idle.
//
//   Ports
//     clk   rising-edge clock
//     aclr  asynchronous reset, active-high
//     bus   conv_mac_stage_if.slave (FIFO read, weight write, result, status)
//
//   Build option
//     CONV_MAC_RELU_EN  when defined, the registered Result is max(sum, 0);
//                       otherwise the raw signed sum. Latency is identical.
// ---------------------------------------------------------------------------
module conv_mac_stage #(
  parameter int DataWidth   = 32,
  parameter int WeightWidth = 8,
  parameter int KernelSize  = 9,
  parameter int TapWidth    = 4,
  parameter int AccWidth    = 44
) (
  input  logic             clk,
  input  logic             aclr,
  conv_mac_stage_if.slave  bus
);

  localparam int ProdWidth = DataWidth + WeightWidth;
  localparam int WDepth    = 1 << TapWidth;

  // pop_cnt carries one extra bit so it can reach KernelSize even when
  // KernelSize == 2**TapWidth.
  localparam logic [TapWidth:0]   KLen  = (TapWidth+1)'(KernelSize);
  localparam logic [TapWidth-1:0] KLast = TapWidth'(KernelSize - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_e;

  state_e                        state_q, state_d;
  logic [TapWidth:0]             pop_cnt_q, pop_cnt_d;
  logic [TapWidth-1:0]           acc_cnt_q, acc_cnt_d;
  logic signed [AccWidth-1:0]    acc_q, acc_d;
  logic                          inflight_q, inflight_d;
  logic [AccWidth-1:0]           result_q, result_d;
  logic                          result_valid_q, result_valid_d;
  logic [WeightWidth-1:0]        weight_q [WDepth];
  logic [WeightWidth-1:0]        weight_d [WDepth];

  logic                          pop;
  logic signed [ProdWidth-1:0]   pix_ext;
  logic signed [ProdWidth-1:0]   wt_ext;
  logic signed [ProdWidth-1:0]   product;
  logic signed [AccWidth-1:0]    window_sum;

  // Pop only while running and while the window still needs pixels.
  assign pop = (state_q == S_RUN) && bus.FifoReady && (pop_cnt_q < KLen);

  // Both operands are sign-extended to the full product width first, so the
  // truncated multiply result is the exact signed product.
  assign pix_ext    = ProdWidth'($signed(bus.FifoData));
  assign wt_ext     = ProdWidth'($signed(weight_q[acc_cnt_q]));
  assign product    = pix_ext * wt_ext;
  assign window_sum = acc_q + AccWidth'(product);

  // NOTE: every next-state variable takes its current value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    pop_cnt_d      = pop_cnt_q;
    acc_cnt_d      = acc_cnt_q;
    acc_d          = acc_q;
    inflight_d     = pop;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    weight_d       = weight_q;

    if (pop) begin
      pop_cnt_d = pop_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.Enable) begin
          state_d = S_RUN;
        end
        if (bus.W_Load && ({1'b0, bus.W_Addr} < KLen)) begin
          weight_d[bus.W_Addr] = bus.W_Data;
        end
      end

      S_RUN: begin
        // Pixel popped last cycle is on FifoData now.
        if (inflight_q) begin
          if (acc_cnt_q == KLast) begin
`ifdef CONV_MAC_RELU_EN
            result_d = window_sum[AccWidth-1] ? '0 : window_sum;
`else
            result_d = window_sum;
`endif
            result_valid_d = 1'b1;
            acc_d          = '0;
            acc_cnt_d      = '0;
            pop_cnt_d      = '0;
            state_d        = S_OUT;
          end else begin
            acc_d     = window_sum;
            acc_cnt_d = acc_cnt_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        // Enable is only looked at here, so a mid-window drop never cuts a
        // window short.
        if (bus.ResultReady) begin
          result_valid_d = 1'b0;
          state_d        = bus.Enable ? S_RUN : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q        <= S_IDLE;
      pop_cnt_q      <= '0;
      acc_cnt_q      <= '0;
      acc_q          <= '0;
      inflight_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      // NOTE: the weight store is a small register file that must read as
      // zero after reset, so it is cleared here rather than left to a RAM.
      for (int i = 0; i < WDepth; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      pop_cnt_q      <= pop_cnt_d;
      acc_cnt_q      <= acc_cnt_d;
      acc_q          <= acc_d;
      inflight_q     <= inflight_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      weight_q       <= weight_d;
    end
  end

  assign bus.Pop         = pop;
  assign bus.Result      = result_q;
  assign bus.ResultValid = result_valid_q;
  assign bus.Busy        = (state_q != S_IDLE);
  assign bus.Test_Tap    = acc_cnt_q;

endmodule

// File: tb/tb_conv_mac_stage.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_stage
//   Self-checking bench for conv_mac_stage. A queue-backed FIFO model answers
//   Pop with one cycle of read latency; expected window results come from a
//   plain dot-product model of the weights and pixels.
// ---------------------------------------------------------------------------
module tb_conv_mac_stage;
  localparam int DW = 32;
  localparam int WW = 8;
  localparam int K  = 9;
  localparam int TW = 4;
  localparam int AW = 44;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  conv_mac_stage_if #(.DataWidth(DW), .WeightWidth(WW), .TapWidth(TW), .AccWidth(AW)) bus ();

  conv_mac_stage #(
    .DataWidth(DW), .WeightWidth(WW), .KernelSize(K), .TapWidth(TW), .AccWidth(AW)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fifo_q[$];
  int pop_cycles[$];
  int gate_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 off
  bit gate_tog  = 1'b0;
  bit pend      = 1'b0;

  // FIFO model: inputs change at negedge, Pop sampled 1 time unit later,
  // popped word presented at the following negedge.
  initial begin
    bit g;
    bus.FifoReady = 1'b0;
    bus.FifoData  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (aclr) pend = 1'b0;
      if (pend && fifo_q.size() > 0) bus.FifoData = fifo_q.pop_front();
      pend = 1'b0;
      gate_tog = ~gate_tog;
      case (gate_mode)
        0:       g = 1'b1;
        1:       g = gate_tog;
        2:       g = 1'($urandom_range(0, 1));
        default: g = 1'b0;
      endcase
      bus.FifoReady = g && (fifo_q.size() > 0);
      #1;
      if (bus.Pop === 1'b1) begin
        n_checks++;
        if (fifo_q.size() == 0) $display("FAIL pop_on_empty: Pop=1 with %0d words queued, need >=1", fifo_q.size());
        else n_pass++;
        pend = 1'b1;
        pop_cycles.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [AW-1:0] model_sum(input int w [K], input int d [K]);
    longint s = 0;
    logic [63:0] t;
    for (int i = 0; i < K; i++) s += longint'(d[i]) * longint'(w[i]);
`ifdef CONV_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    t = s;
    return t[AW-1:0];
  endfunction

  task automatic load_weights(input int w [K]);
    for (int i = 0; i < K; i++) begin
      bus.W_Load = 1'b1;
      bus.W_Addr = TW'(i);
      bus.W_Data = WW'(w[i]);
      tick();
    end
    bus.W_Load = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.ResultValid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake(input int rdelay);
    repeat (rdelay) tick();
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
  endtask

  task automatic run_window(input int w [K], input int d [K], input bit do_load,
                            input int mode, input int rdelay,
                            output logic [AW-1:0] got, output bit ok, output int vcyc);
    if (do_load) load_weights(w);
    for (int i = 0; i < K; i++) fifo_q.push_back(d[i]);
    gate_mode = mode;
    pop_cycles.delete();
    bus.Enable = 1'b1;
    wait_valid(ok);
    got  = bus.Result;
    vcyc = cyc;
    bus.Enable = 1'b0;
    if (ok) handshake(rdelay);
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if (bus.Pop !== 1'b0 || bus.ResultValid !== 1'b0 || bus.Busy !== 1'b0)
      $display("FAIL reset_ctrl: Pop=%b RV=%b Busy=%b, need 0 0 0", bus.Pop, bus.ResultValid, bus.Busy);
    else n_pass++;
    n_checks++;
    if (bus.Result !== '0 || bus.Test_Tap !== '0)
      $display("FAIL reset_data: Result=%h Tap=%0d, need 0 0", bus.Result, bus.Test_Tap);
    else n_pass++;
    aclr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_window();
    int w [K];
    int d [K];
    int z [K];
    bit found = 1'b0;
    bit ok;
    int vc;
    logic [AW-1:0] got;
    for (int i = 0; i < K; i++) begin w[i] = 1; d[i] = i + 1; z[i] = 0; end
    load_weights(w);
    for (int i = 0; i < K; i++) fifo_q.push_back(d[i]);
    gate_mode = 0;
    bus.Enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.Test_Tap === TW'(4)) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL midreset_reach_tap4: Test_Tap=%0d, need 4", bus.Test_Tap);
    else n_pass++;
    aclr = 1'b1;
    #1;
    n_checks++;
    if (bus.Pop !== 1'b0 || bus.ResultValid !== 1'b0 || bus.Result !== '0 ||
        bus.Busy !== 1'b0 || bus.Test_Tap !== '0)
      $display("FAIL midreset_outputs: Pop=%b RV=%b Result=%h Busy=%b Tap=%0d, need all 0",
               bus.Pop, bus.ResultValid, bus.Result, bus.Busy, bus.Test_Tap);
    else n_pass++;
    bus.Enable = 1'b0;
    tick();
    aclr = 1'b0;
    fifo_q.delete();
    tick();
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL midreset_idle: Busy=%b, need 0", bus.Busy);
    else n_pass++;
    // Weights were cleared by reset: a window without reloading sums to zero.
    run_window(z, d, 1'b0, 0, 0, got, ok, vc);
    n_checks++;
    if (!ok || got !== model_sum(z, d))
      $display("FAIL weights_cleared: ok=%b Result=%h, need %h", ok, got, model_sum(z, d));
    else n_pass++;
  endtask

  task automatic test_basic_sum();
    int w [K];
    int d [K];
    bit ok;
    int vc;
    logic [AW-1:0] got;
    for (int i = 0; i < K; i++) begin w[i] = 1; d[i] = i + 1; end
    run_window(w, d, 1'b1, 0, 0, got, ok, vc);
    n_checks++;
    if (!ok || got !== model_sum(w, d))
      $display("FAIL basic_sum: ok=%b Result=%0d, need %0d", ok, got, model_sum(w, d));
    else n_pass++;
    n_checks++;
    if (pop_cycles.size() != K || pop_cycles[K-1] - pop_cycles[0] != K - 1)
      $display("FAIL basic_pop_burst: pops=%0d span=%0d, need %0d pops span %0d",
               pop_cycles.size(), pop_cycles.size() > 0 ? pop_cycles[$] - pop_cycles[0] : -1, K, K - 1);
    else n_pass++;
    n_checks++;
    if (pop_cycles.size() == 0 || vc != pop_cycles[$] + 2)
      $display("FAIL basic_latency: valid at cycle %0d, need last pop cycle + 2", vc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w [K];
    int d [K];
    bit ok;
    logic [AW-1:0] expv;
    for (int i = 0; i < K; i++) begin w[i] = i; d[i] = -2; end
    expv = model_sum(w, d);
    load_weights(w);
    for (int r = 0; r < 2; r++) for (int i = 0; i < K; i++) fifo_q.push_back(d[i]);
    gate_mode = 0;
    pop_cycles.delete();
    bus.Enable = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok) $display("FAIL bp_first_valid: timeout waiting for ResultValid");
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.Result !== expv || bus.ResultValid !== 1'b1 || bus.Pop !== 1'b0)
        $display("FAIL bp_hold_%0d: Result=%h RV=%b Pop=%b, need %h 1 0",
                 i, bus.Result, bus.ResultValid, bus.Pop, expv);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (pop_cycles.size() != K) $display("FAIL bp_pop_count: pops=%0d, need %0d", pop_cycles.size(), K);
    else n_pass++;
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
    n_checks++;
    if (bus.ResultValid !== 1'b0 || bus.Pop !== 1'b1)
      $display("FAIL bp_resume: RV=%b Pop=%b, need 0 1", bus.ResultValid, bus.Pop);
    else n_pass++;
    wait_valid(ok);
    n_checks++;
    if (!ok || bus.Result !== expv)
      $display("FAIL bp_second: ok=%b Result=%h, need %h", ok, bus.Result, expv);
    else n_pass++;
    bus.Enable = 1'b0;
    handshake(0);
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL bp_idle: Busy=%b, need 0", bus.Busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int w [K];
    int d [K];
    bit ok;
    int vc;
    logic [AW-1:0] got;
    for (int i = 0; i < K; i++) begin w[i] = 1; d[i] = 3; end
    run_window(w, d, 1'b1, 1, 2, got, ok, vc);
    n_checks++;
    if (!ok || got !== model_sum(w, d))
      $display("FAIL stall_sum: ok=%b Result=%0d, need %0d", ok, got, model_sum(w, d));
    else n_pass++;
    n_checks++;
    if (pop_cycles.size() != K || pop_cycles[K-1] - pop_cycles[0] != 2 * (K - 1))
      $display("FAIL stall_pops: pops=%0d, need %0d on alternate cycles", pop_cycles.size(), K);
    else n_pass++;
  endtask

  task automatic test_wload_and_enable_drop();
    int w [K];
    int d [K];
    bit ok;
    bit found = 1'b0;
    for (int i = 0; i < K; i++) begin
      w[i] = int'($urandom_range(0, 255)) - 128;
      d[i] = int'($urandom_range(0, 2000)) - 1000;
    end
    d[0] = 5;
    load_weights(w);
    for (int i = 0; i < K; i++) fifo_q.push_back(d[i]);
    gate_mode = 3;
    bus.Enable = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.Busy !== 1'b1) $display("FAIL wl_run: Busy=%b, need 1", bus.Busy);
    else n_pass++;
    bus.W_Load = 1'b1;
    bus.W_Addr = '0;
    bus.W_Data = ~WW'(w[0]);
    tick();
    bus.W_Load = 1'b0;
    gate_mode = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.Test_Tap === TW'(3)) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL wl_reach_tap3: Test_Tap=%0d, need 3", bus.Test_Tap);
    else n_pass++;
    bus.Enable = 1'b0;
    wait_valid(ok);
    n_checks++;
    if (!ok || bus.Result !== model_sum(w, d))
      $display("FAIL wl_sum: ok=%b Result=%h, need %h", ok, bus.Result, model_sum(w, d));
    else n_pass++;
    n_checks++;
    if (bus.Busy !== 1'b1) $display("FAIL wl_out_busy: Busy=%b, need 1", bus.Busy);
    else n_pass++;
    handshake(1);
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.ResultValid !== 1'b0)
      $display("FAIL wl_idle: Busy=%b RV=%b, need 0 0", bus.Busy, bus.ResultValid);
    else n_pass++;
  endtask

  task automatic test_relu();
    int w [K];
    int d [K];
    bit ok;
    int vc;
    logic [AW-1:0] got;
    logic [AW-1:0] expv;
    for (int i = 0; i < K; i++) begin w[i] = 1; d[i] = -1; end
`ifdef CONV_MAC_RELU_EN
    expv = '0;
`else
    expv = AW'(-9);
`endif
    run_window(w, d, 1'b1, 0, 0, got, ok, vc);
    n_checks++;
    if (!ok || got !== expv) $display("FAIL relu_window: ok=%b Result=%h, need %h", ok, got, expv);
    else n_pass++;
  endtask

  task automatic test_random();
    int w [K];
    int d [K];
    bit ok;
    int vc;
    logic [AW-1:0] got;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < K; i++) begin
        w[i] = int'($urandom_range(0, 255)) - 128;
        d[i] = int'($urandom());
      end
      run_window(w, d, 1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), got, ok, vc);
      n_checks++;
      if (!ok || got !== model_sum(w, d))
        $display("FAIL random_%0d: ok=%b Result=%h, need %h", t, ok, got, model_sum(w, d));
      else n_pass++;
    end
  endtask

  initial begin
    aclr            = 1'b1;
    bus.Enable      = 1'b0;
    bus.W_Load      = 1'b0;
    bus.W_Addr      = '0;
    bus.W_Data      = '0;
    bus.ResultReady = 1'b0;
    test_reset();
    test_reset_mid_window();
    test_basic_sum();
    test_backpressure();
    test_stall();
    test_wload_and_enable_drop();
    test_relu();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
